// File: rtl/exu_pkg.sv
// EX-stage shared codes: ALU control, R-type funct, branch types.
package exu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_NOR  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_SLL  = 5'd10;
  localparam logic [4:0] ALU_SRL  = 5'd11;
  localparam logic [4:0] ALU_SRA  = 5'd12;
  localparam logic [4:0] ALU_LUI  = 5'd13;

  localparam logic [4:0] OP_RTYPE = 5'h1F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLTZ = 3'd3;
  localparam logic [2:0] BR_BGEZ = 3'd4;
  localparam logic [2:0] BR_JUMP = 3'd5;

endpackage

// File: rtl/exu_alu.sv
// Combinational 32-bit ALU for the EX stage.
// Signed overflow on ADD/SUB only when EXU_OVERFLOW_EN is defined.
module exu_alu
  import exu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [4:0]    ctrl,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          ovf
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic [4:0]    sh;

  assign sum  = a + b;
  assign diff = a - b;
  assign sh   = a[4:0];

  always_comb begin
    result = '0;
    unique case (ctrl)
      ALU_ADD, ALU_ADDU: result = sum;
      ALU_SUB, ALU_SUBU: result = diff;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:
        result = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:
        result = {{(DW-1){1'b0}}, a < b};
      ALU_SLL:  result = b << sh;
      ALU_SRL:  result = b >> sh;
      ALU_SRA:  result = $signed(b) >>> sh;
      ALU_LUI:  result = b << 16;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef EXU_OVERFLOW_EN
  logic add_ovf;
  logic sub_ovf;

  // sign of result disagrees with the operands' common sign
  assign add_ovf = (a[DW-1] == b[DW-1]) &&
                   (sum[DW-1] != a[DW-1]);
  assign sub_ovf = (a[DW-1] != b[DW-1]) &&
                   (diff[DW-1] != a[DW-1]);
  assign ovf = ((ctrl == ALU_ADD) && add_ovf) ||
               ((ctrl == ALU_SUB) && sub_ovf);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/exec_branch_unit.sv
// EX-stage execute: ALU-control decode, ALU, EX/MEM register, branch resolve.
// Optional signed-overflow detection via EXU_OVERFLOW_EN.
module exec_branch_unit
  import exu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    alu_op,
  input  logic [5:0]    funct,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic [2:0]    br_type_in,
  input  logic          flush,
  output logic [4:0]    alu_ctrl,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          ovf,
  output logic [DW-1:0] mem_result,
  output logic          mem_zero,
  output logic [2:0]    mem_br_type,
  output logic          pc_src
);

  always_comb begin
    alu_ctrl = alu_op;
    if (alu_op == OP_RTYPE) begin
      unique case (funct)
        FN_ADD:           alu_ctrl = ALU_ADD;
        FN_ADDU:          alu_ctrl = ALU_ADDU;
        FN_SUB:           alu_ctrl = ALU_SUB;
        FN_SUBU:          alu_ctrl = ALU_SUBU;
        FN_AND:           alu_ctrl = ALU_AND;
        FN_OR:            alu_ctrl = ALU_OR;
        FN_XOR:           alu_ctrl = ALU_XOR;
        FN_NOR:           alu_ctrl = ALU_NOR;
        FN_SLT:           alu_ctrl = ALU_SLT;
        FN_SLTU:          alu_ctrl = ALU_SLTU;
        FN_SLL, FN_SLLV:  alu_ctrl = ALU_SLL;
        FN_SRL, FN_SRLV:  alu_ctrl = ALU_SRL;
        FN_SRA, FN_SRAV:  alu_ctrl = ALU_SRA;
        // jr and friends still need a harmless pass-through
        default:          alu_ctrl = ALU_ADDU;
      endcase
    end
  end

  exu_alu #(
    .DW(DW)
  ) u_alu (
    .ctrl   (alu_ctrl),
    .a      (src_a),
    .b      (src_b),
    .result (result),
    .zero   (zero),
    .ovf    (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_result  <= '0;
      mem_zero    <= 1'b0;
      mem_br_type <= BR_NONE;
    end else if (flush) begin
      mem_result  <= '0;
      mem_zero    <= 1'b0;
      mem_br_type <= BR_NONE;
    end else begin
      mem_result  <= result;
      mem_zero    <= zero;
      mem_br_type <= br_type_in;
    end
  end

  always_comb begin
    pc_src = 1'b0;
    unique case (mem_br_type)
      BR_BEQ:  pc_src = mem_zero;
      BR_BNE:  pc_src = ~mem_zero;
      BR_BLTZ: pc_src = mem_result[0];
      BR_BGEZ: pc_src = ~mem_result[0];
      BR_JUMP: pc_src = 1'b1;
      default: pc_src = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exec_branch_unit.sv
// Randomized bench for exec_branch_unit against a behavioural model.
module tb_exec_branch_unit;

  localparam int DW = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    alu_op;
  logic [5:0]    funct;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic [2:0]    br_type_in;
  logic          flush;
  logic [4:0]    alu_ctrl;
  logic [DW-1:0] result;
  logic          zero;
  logic          ovf;
  logic [DW-1:0] mem_result;
  logic          mem_zero;
  logic [2:0]    mem_br_type;
  logic          pc_src;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  logic [31:0] exp_mem_result;
  logic        exp_mem_zero;
  logic [2:0]  exp_mem_br;

`ifdef EXU_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  exec_branch_unit #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_op      (alu_op),
    .funct       (funct),
    .src_a       (src_a),
    .src_b       (src_b),
    .br_type_in  (br_type_in),
    .flush       (flush),
    .alu_ctrl    (alu_ctrl),
    .result      (result),
    .zero        (zero),
    .ovf         (ovf),
    .mem_result  (mem_result),
    .mem_zero    (mem_zero),
    .mem_br_type (mem_br_type),
    .pc_src      (pc_src)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned m_ctrl(logic [4:0] op,
                                         logic [5:0] f);
    if (op != 5'h1F) return int'(op);
    case (f)
      6'h20: return 0;
      6'h21: return 1;
      6'h22: return 2;
      6'h23: return 3;
      6'h24: return 4;
      6'h25: return 5;
      6'h26: return 6;
      6'h27: return 7;
      6'h2A: return 8;
      6'h2B: return 9;
      6'h00, 6'h04: return 10;
      6'h02, 6'h06: return 11;
      6'h03, 6'h07: return 12;
      default: return 1;
    endcase
  endfunction

  // returns {ovf, result}
  function automatic logic [32:0] m_alu(int unsigned c,
                                        logic [31:0] a,
                                        logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint s;
    logic [31:0] r = 32'd0;
    logic o = 1'b0;
    case (c)
      0, 1: begin
        s = sa + sb;
        r = s[31:0];
        o = (c == 0) && (s > MAXI || s < MINI);
      end
      2, 3: begin
        s = sa - sb;
        r = s[31:0];
        o = (c == 2) && (s > MAXI || s < MINI);
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = ~(a | b);
      8: r = (sa < sb) ? 32'd1 : 32'd0;
      9: r = (ua < ub) ? 32'd1 : 32'd0;
      10: r = b << a[4:0];
      11: r = b >> a[4:0];
      12: begin
        s = sb >>> a[4:0];
        r = s[31:0];
      end
      13: r = {b[15:0], 16'h0000};
      default: r = 32'd0;
    endcase
    if (!OVF_ON) o = 1'b0;
    return {o, r};
  endfunction

  function automatic logic m_taken(logic [2:0] t, logic z,
                                   logic r0);
    case (t)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return r0;
      3'd4: return !r0;
      3'd5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // expected MEM-stage contents
  always @(posedge clk or posedge rst) begin
    logic [32:0] m;
    if (rst || flush) begin
      exp_mem_result = 32'd0;
      exp_mem_zero   = 1'b0;
      exp_mem_br     = 3'd0;
    end else begin
      m = m_alu(m_ctrl(alu_op, funct), src_a, src_b);
      exp_mem_result = m[31:0];
      exp_mem_zero   = (m[31:0] == 32'd0);
      exp_mem_br     = br_type_in;
    end
  end

  always @(negedge clk) begin
    int unsigned c;
    logic [32:0] m;
    if (chk_on && !rst) begin
      c = m_ctrl(alu_op, funct);
      m = m_alu(c, src_a, src_b);
      check("alu_ctrl", 64'(alu_ctrl), 64'(c));
      check("result", 64'(result), 64'(m[31:0]));
      check("zero", 64'(zero), 64'(m[31:0] == 32'd0));
      check("ovf", 64'(ovf), 64'(m[32]));
      check("mem_result", 64'(mem_result),
            64'(exp_mem_result));
      check("mem_zero", 64'(mem_zero), 64'(exp_mem_zero));
      check("mem_br_type", 64'(mem_br_type),
            64'(exp_mem_br));
      check("pc_src", 64'(pc_src),
            64'(m_taken(exp_mem_br, exp_mem_zero,
                        exp_mem_result[0])));
    end
  end

  task automatic step(logic [4:0] op, logic [5:0] f,
                      logic [31:0] a, logic [31:0] b,
                      logic [2:0] br, logic fl);
    @(posedge clk);
    #1;
    alu_op     = op;
    funct      = f;
    src_a      = a;
    src_b      = b;
    br_type_in = br;
    flush      = fl;
  endtask

  logic [5:0] fn_list [0:17] = '{
    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
    6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h3F
  };
  logic [31:0] corner [0:5] = '{
    32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
    32'hFFFFFFFF, 32'h0000ABCD
  };

  function automatic logic [31:0] rand_opnd();
    if ($urandom_range(0, 3) == 0)
      return corner[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [4:0] op;
    rst        = 1'b1;
    alu_op     = 5'd0;
    funct      = 6'd0;
    src_a      = 32'd0;
    src_b      = 32'd0;
    br_type_in = 3'd0;
    flush      = 1'b0;
    #2;
    check("rst_mem_result", 64'(mem_result), 64'd0);
    check("rst_mem_zero", 64'(mem_zero), 64'd0);
    check("rst_mem_br_type", 64'(mem_br_type), 64'd0);
    check("rst_pc_src", 64'(pc_src), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    step(5'h1F, 6'h20, 32'h7FFFFFFF, 32'h1, 3'd0, 1'b0);
    #1;
    check("add_ovf_res", 64'(result), 64'h80000000);
    check("add_ovf_ovf", 64'(ovf), 64'(OVF_ON));
    check("add_ovf_zero", 64'(zero), 64'd0);
    step(5'h1F, 6'h03, 32'h4, 32'hF0000000, 3'd0, 1'b0);
    #1 check("sra_res", 64'(result), 64'hFF000000);
    step(5'h1F, 6'h02, 32'h4, 32'hF0000000, 3'd0, 1'b0);
    #1 check("srl_res", 64'(result), 64'h0F000000);
    step(5'd8, 6'h00, 32'hFFFFFFFF, 32'h1, 3'd0, 1'b0);
    #1 check("slt_res", 64'(result), 64'd1);
    step(5'd9, 6'h00, 32'hFFFFFFFF, 32'h1, 3'd0, 1'b0);
    #1;
    check("sltu_res", 64'(result), 64'd0);
    check("sltu_zero", 64'(zero), 64'd1);
    step(5'd13, 6'h00, 32'h0, 32'h0000ABCD, 3'd0, 1'b0);
    #1 check("lui_res", 64'(result), 64'hABCD0000);
    step(5'h1F, 6'h3F, 32'h0, 32'h0, 3'd0, 1'b0);
    #1 check("dflt_ctrl", 64'(alu_ctrl), 64'd1);

    step(5'd2, 6'h00, 32'd5, 32'd5, 3'd1, 1'b0);
    step(5'd2, 6'h00, 32'd5, 32'd5, 3'd2, 1'b0);
    #1;
    check("beq_mem_zero", 64'(mem_zero), 64'd1);
    check("beq_pc_src", 64'(pc_src), 64'd1);
    step(5'd0, 6'h00, 32'd0, 32'd0, 3'd0, 1'b0);
    #1 check("bne_pc_src", 64'(pc_src), 64'd0);
    step(5'd2, 6'h00, 32'd5, 32'd5, 3'd1, 1'b1);
    step(5'd0, 6'h00, 32'd0, 32'd0, 3'd0, 1'b0);
    #1 check("flush_pc_src", 64'(pc_src), 64'd0);

    step(5'd2, 6'h00, 32'd5, 32'd5, 3'd1, 1'b0);
    step(5'd0, 6'h00, 32'd1, 32'd0, 3'd0, 1'b0);
    #1 check("pre_rst_pc_src", 64'(pc_src), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pc_src", 64'(pc_src), 64'd0);
    check("async_rst_zero", 64'(mem_zero), 64'd0);
    #2 rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) op = 5'h1F;
      else op = 5'($urandom_range(0, 31));
      step(op, fn_list[$urandom_range(0, 17)],
           rand_opnd(), rand_opnd(),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0));
    end

    @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
